mem_wb_stage: RTL



---
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// M and W stages of the P5 MIPS pipeline: E/M register, word-addressed data
// memory, M/W register and the register-file write port derived from W.
module mem_wb_stage #(
  parameter int DM_WORDS = 3072,
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] e_instr,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_aluout,
  input  logic [31:0] e_DMinput,
  input  logic [31:0] em_out,
  output logic [31:0] m_instr,
  output logic [31:0] m_pc,
  output logic [31:0] m_fw,
  output logic [4:0]  m_wa,
  output logic [31:0] w_instr,
  output logic [31:0] w_pc,
  output logic        w_we,
  output logic [4:0]  w_wa,
  output logic [31:0] w_wd
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;

  // Destination register of an instruction; 0 means the instruction writes nothing.
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    logic [4:0] r;
    r = '0;
    case (instr[31:26])
      OP_SPECIAL: if (instr[5:0] == FN_ADD || instr[5:0] == FN_SUB) r = instr[15:11];
      OP_ORI, OP_LUI, OP_LW: r = instr[20:16];
      OP_JAL: r = 5'(LINK_REG);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Word index; a non-power-of-two depth folds the top slice back into range.
  function automatic logic [AW-1:0] dm_index(input logic [31:0] addr);
    logic [AW-1:0] raw;
    raw = addr[AW+1:2];
    if ({{(32-AW){1'b0}}, raw} >= 32'(DM_WORDS)) raw = raw - AW'(DM_WORDS);
    return raw;
  endfunction

  logic [31:0] m_instr_q, m_instr_d, m_pc_q, m_pc_d;
  logic [31:0] m_aluout_q, m_aluout_d, m_store_q, m_store_d, m_fw_q, m_fw_d;
  logic [31:0] w_instr_q, w_instr_d, w_pc_q, w_pc_d;
  logic [31:0] w_rdata_q, w_rdata_d, w_fw_q, w_fw_d;

  logic [31:0]   mem_q [DM_WORDS];
  logic [AW-1:0] m_idx;
  logic          dm_we;
  logic [31:0]   dm_rdata;
  logic          unused_addr_bits;

  assign m_idx            = dm_index(m_aluout_q);
  assign dm_we            = (m_instr_q[31:26] == OP_SW);
  assign dm_rdata         = mem_q[m_idx];
  assign unused_addr_bits = ^{m_aluout_q[31:AW+2], m_aluout_q[1:0]};

  always_comb begin
    m_instr_d  = e_instr;
    m_pc_d     = e_pc;
    m_aluout_d = e_aluout;
    m_store_d  = e_DMinput;
    m_fw_d     = em_out;
    w_instr_d  = m_instr_q;
    w_pc_d     = m_pc_q;
    w_rdata_d  = dm_rdata;
    w_fw_d     = m_fw_q;
  end

  // E/M and M/W pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_instr_q  <= '0;
      m_pc_q     <= '0;
      m_aluout_q <= '0;
      m_store_q  <= '0;
      m_fw_q     <= '0;
      w_instr_q  <= '0;
      w_pc_q     <= '0;
      w_rdata_q  <= '0;
      w_fw_q     <= '0;
    end else begin
      m_instr_q  <= m_instr_d;
      m_pc_q     <= m_pc_d;
      m_aluout_q <= m_aluout_d;
      m_store_q  <= m_store_d;
      m_fw_q     <= m_fw_d;
      w_instr_q  <= w_instr_d;
      w_pc_q     <= w_pc_d;
      w_rdata_q  <= w_rdata_d;
      w_fw_q     <= w_fw_d;
    end
  end

  // Data memory: reset wipes every word, so a store caught in M is lost too
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (dm_we) begin
      mem_q[m_idx] <= m_store_q;
    end
  end

  assign m_instr = m_instr_q;
  assign m_pc    = m_pc_q;
  assign m_fw    = m_fw_q;
  assign m_wa    = dest_reg(m_instr_q);
  assign w_instr = w_instr_q;
  assign w_pc    = w_pc_q;
  assign w_wa    = dest_reg(w_instr_q);
  assign w_we    = (w_wa != 5'd0);
  assign w_wd    = (w_instr_q[31:26] == OP_LW) ? w_rdata_q : w_fw_q;

endmodule
